// File: rtl/flash_loader.sv
`default_nettype none
// ============================================================================
// Module   : flash_loader
// Brief    : Length-prefixed byte stream to 32-bit flash word writer. Holds
//            the core in reset until the image is loaded. Optional trailing
//            XOR checksum byte when FLASH_LOADER_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module flash_loader #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          CNT_BYTES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             flash_en,
    output logic             core_rst,
    output logic             done,
    output logic             err
);

    localparam int CW = 8 * CNT_BYTES;
    localparam int BW = (CNT_BYTES > 4) ? $clog2(CNT_BYTES) : 2;

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3
`ifdef FLASH_LOADER_CHECKSUM_EN
        ,
        S_CHK   = 3'd4,
        S_ERR   = 3'd5
`endif
    } state_t;

`ifdef FLASH_LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CHK;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t           state, state_n;
    logic [BW-1:0]    byte_idx, byte_idx_n;
    logic [CW-1:0]    word_idx, word_idx_n;
    logic [CW-1:0]    count, count_n;
    logic [WIDTH-1:0] word, word_n;
    logic [WIDTH-1:0] flash_addr_n, flash_data_n;
    logic [7:0]       csum, csum_n;
    logic             xfer;

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_n      = state;
        byte_idx_n   = byte_idx;
        word_idx_n   = word_idx;
        count_n      = count;
        word_n       = word;
        flash_addr_n = flash_addr;
        flash_data_n = flash_data;
        csum_n       = csum;
        case (state)
            S_HDR: begin
                if (xfer) begin
                    // Shift in from the top so the first (LSB) byte lands at the bottom.
                    count_n = {in_data, count[CW-1:8]};
                    if (byte_idx == BW'(CNT_BYTES - 1)) begin
                        byte_idx_n = '0;
                        state_n    = (count_n == '0) ? S_END : S_DATA;
                    end else begin
                        byte_idx_n = byte_idx + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_n = {in_data, word[WIDTH-1:8]};
                    csum_n = csum ^ in_data;
                    if (byte_idx == BW'(3)) begin
                        byte_idx_n   = '0;
                        flash_data_n = word_n;
                        flash_addr_n = WIDTH'(BASE_ADDR) + WIDTH'({word_idx, 2'b00});
                        state_n      = S_WRITE;
                    end else begin
                        byte_idx_n = byte_idx + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                word_idx_n = word_idx + CW'(1);
                state_n    = (word_idx_n == count) ? S_END : S_DATA;
            end
`ifdef FLASH_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    state_n = (in_data == csum) ? S_DONE : S_ERR;
                end
            end
            S_ERR: ;
`endif
            S_DONE: ;
            default: state_n = S_HDR;
        endcase
    end

    // Outputs are registered from the next state so they change on entry.
    logic in_ready_n, done_n, err_n;
    always_comb begin
        in_ready_n = (state_n == S_HDR) || (state_n == S_DATA);
        err_n      = 1'b0;
`ifdef FLASH_LOADER_CHECKSUM_EN
        in_ready_n = in_ready_n || (state_n == S_CHK);
        err_n      = (state_n == S_ERR);
`endif
        done_n     = (state_n == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_HDR;
            byte_idx   <= '0;
            word_idx   <= '0;
            count      <= '0;
            word       <= '0;
            csum       <= '0;
            in_ready   <= 1'b0;
            flash_en   <= 1'b0;
            flash_addr <= '0;
            flash_data <= '0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            byte_idx   <= byte_idx_n;
            word_idx   <= word_idx_n;
            count      <= count_n;
            word       <= word_n;
            csum       <= csum_n;
            in_ready   <= in_ready_n;
            flash_en   <= (state_n == S_WRITE);
            flash_addr <= flash_addr_n;
            flash_data <= flash_data_n;
            core_rst   <= !done_n;
            done       <= done_n;
        end
    end

`ifdef FLASH_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= err_n;
        end
    end
`else
    assign err = 1'b0;
    logic unused_ok;
    assign unused_ok = &{1'b0, err_n, csum_n};
`endif

endmodule
`default_nettype wire
